div_checker: RTL and testbench

DIV_CHECKER -- requirements
Module: div_checker

---
 rtl/div_checker_if.sv | 23 ++
 rtl/div_checker.sv | 159 +++++++++++++++
 tb/tb_div_checker.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/div_checker_if.sv
// Bus between a divided-clock source and div_checker: the clock under test
// and the measurement/lock/error results.
interface div_checker_if #(
  parameter int CNT_W = 8
);
  logic             div_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             locked;
  logic             err;
  logic [7:0]       err_cnt;

  modport master (
    output div_in,
    input  period, high_time, meas_valid, locked, err, err_cnt
  );

  modport slave (
    input  div_in,
    output period, high_time, meas_valid, locked, err, err_cnt
  );
endinterface

// File: rtl/div_checker.sv
// Measures period/high time of an asynchronous divided clock and tracks lock
// against the expected N-cycle period with EXP_HIGH-cycle high phase.
module div_checker #(
  parameter int N           = 7,
  parameter int EXP_HIGH    = 1,
  parameter int LOCK_CNT    = 4,
  parameter int TIMEOUT_CYC = 28,
  parameter int CNT_W       = 8
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  div_checker_if.slave bus
);
  localparam int MC_W = $clog2(LOCK_CNT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACQ  = 2'd1;
  localparam logic [1:0] S_LOCK = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] N_C     = CNT_W'(N);
  localparam logic [CNT_W-1:0] HIGH_C  = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TIMEOUT_CYC);
  localparam logic [MC_W-1:0]  LOCK_C  = MC_W'(LOCK_CNT);

  logic             sync1_q, sync1_d;
  logic             sync_q, sync_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             meas_valid_q, meas_valid_d;
  logic [1:0]       state_q, state_d;
  logic [MC_W-1:0]  mc_q, mc_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic             rise, fall, match, timeout;
  logic [MC_W-1:0]  mc_inc;

  always_comb begin
    sync1_d = bus.div_in;
    sync_d  = sync1_q;
    prev_d  = sync_q;

    rise    = sync_q & ~prev_q;
    fall    = ~sync_q & prev_q;
    match   = (cnt_q == N_C) && (high_time_q == HIGH_C);
    // A rise landing exactly on the timeout count is a valid (long) period.
    timeout = (state_q != S_IDLE) && (cnt_q == TO_C) && !rise;
    mc_inc  = mc_q + MC_W'(1);

    if (rise)                              cnt_d = CNT_W'(1);
    else if (state_q == S_IDLE || timeout) cnt_d = '0;
    else if (cnt_q != CNT_MAX)             cnt_d = cnt_q + CNT_W'(1);
    else                                   cnt_d = cnt_q;

    if (rise)                          hi_d = CNT_W'(1);
    else if (sync_q && hi_q != CNT_MAX) hi_d = hi_q + CNT_W'(1);
    else                               hi_d = hi_q;

    high_time_d  = fall ? hi_q : high_time_q;
    period_d     = period_q;
    meas_valid_d = 1'b0;
    if (rise && state_q != S_IDLE) begin
      period_d     = cnt_q;
      meas_valid_d = 1'b1;
    end

    state_d = state_q;
    mc_d    = mc_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_ACQ;
          mc_d    = '0;
        end
      end
      S_ACQ: begin
        if (rise) begin
          if (!match) begin
            mc_d = '0;
          end else if (mc_inc == LOCK_C) begin
            state_d = S_LOCK;
            mc_d    = '0;
          end else begin
            mc_d = mc_inc;
          end
        end else if (timeout) begin
          state_d = S_IDLE;
          mc_d    = '0;
          err_d   = 1'b1;
        end
      end
      S_LOCK: begin
        if (rise) begin
          if (!match) begin
            state_d = S_ACQ;
            mc_d    = '0;
            err_d   = 1'b1;
          end
        end else if (timeout) begin
          state_d = S_IDLE;
          mc_d    = '0;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        mc_d    = '0;
      end
    endcase

    locked_d  = (state_d == S_LOCK);
    err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q      <= 1'b0;
      sync_q       <= 1'b0;
      prev_q       <= 1'b0;
      cnt_q        <= '0;
      hi_q         <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      meas_valid_q <= 1'b0;
      state_q      <= S_IDLE;
      mc_q         <= '0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      meas_valid_q <= meas_valid_d;
      state_q      <= state_d;
      mc_q         <= mc_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign bus.period     = period_q;
  assign bus.high_time  = high_time_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.locked     = locked_q;
  assign bus.err        = err_q;
  assign bus.err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_div_checker.sv
// Randomized bench for div_checker: a pulse-level model predicts every
// measurement, the lock state and the error count.
module tb_div_checker;
  localparam int N  = 7;
  localparam int EH = 1;
  localparam int LK = 4;
  localparam int TO = 28;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  always #5 sys_clk = ~sys_clk;

  div_checker_if #(.CNT_W(8)) bus();

  div_checker #(.N(N), .EXP_HIGH(EH), .LOCK_CNT(LK), .TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_cmp++;
    if (obs != exp_v) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Model: 0 idle, 1 acquire, 2 locked; operates per rising edge of div_in.
  int m_st, m_mc, m_errs, m_prev_p, m_prev_h;
  int exp_p[$];
  int exp_h[$];
  int err_seen = 0;
  int err_base = 0;

  always @(negedge sys_clk) begin
    if (sys_rst_n === 1'b1) begin
      if (bus.err) err_seen++;
      if (bus.meas_valid) begin
        if (exp_p.size() == 0) chk("meas_unexpected", 1, 0);
        else begin
          chk("period", bus.period, exp_p.pop_front());
          chk("high_time", bus.high_time, exp_h.pop_front());
        end
      end
    end
  end

  task automatic model_rise();
    bit m;
    if (m_st != 0 && m_prev_p > TO) begin
      m_errs++; m_st = 0; m_mc = 0;
    end
    if (m_st == 0) begin
      m_st = 1; m_mc = 0;
    end else begin
      exp_p.push_back(m_prev_p);
      exp_h.push_back(m_prev_h);
      m = (m_prev_p == N) && (m_prev_h == EH);
      if (m_st == 1) begin
        if (m) begin
          m_mc++;
          if (m_mc == LK) begin m_st = 2; m_mc = 0; end
        end else m_mc = 0;
      end else if (!m) begin
        m_errs++; m_st = 1; m_mc = 0;
      end
    end
  endtask

  task automatic checkpoint();
    chk("locked", bus.locked, (m_st == 2) ? 1 : 0);
    chk("err_cnt", bus.err_cnt, (m_errs > 255) ? 255 : m_errs);
    chk("err_pulses", err_seen - err_base, m_errs);
  endtask

  // One div_in period: h cycles high, l low; checked 4 cycles after the rise.
  task automatic pulse(input int h, input int l);
    model_rise();
    bus.div_in = 1'b1;
    for (int k = 1; k <= h + l; k++) begin
      @(negedge sys_clk);
      if (k == h) bus.div_in = 1'b0;
      if (k == 4) checkpoint();
    end
    m_prev_p = h + l;
    m_prev_h = h;
  endtask

  task automatic hold_low(input int c);
    bus.div_in = 1'b0;
    repeat (c) @(negedge sys_clk);
    if (m_st != 0 && m_prev_p + c > TO) begin
      m_errs++; m_st = 0; m_mc = 0;
    end
    m_prev_p += c;
    checkpoint();
  endtask

  task automatic model_reset();
    m_st = 0; m_mc = 0; m_errs = 0; m_prev_p = 0; m_prev_h = 0;
    err_base = err_seen;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_period"}, bus.period, 0);
    chk({tag, "_high"}, bus.high_time, 0);
    chk({tag, "_mv"}, bus.meas_valid, 0);
    chk({tag, "_locked"}, bus.locked, 0);
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_errcnt"}, bus.err_cnt, 0);
  endtask

  initial begin
    int h, p;
    sys_rst_n  = 1'b0;
    bus.div_in = 1'b0;
    model_reset();
    repeat (3) @(negedge sys_clk);
    check_zero("rst");
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // Nominal 1-high/6-low: lock on the 5th rise.
    for (int i = 0; i < 10; i++) begin
      pulse(1, 6);
      chk("lock_on_5th", bus.locked, (i >= 4) ? 1 : 0);
    end

    // One stretched period while locked, then relock.
    pulse(1, 7);
    pulse(1, 6);
    chk("stretch_unlock", bus.locked, 0);
    chk("stretch_errcnt", bus.err_cnt, 1);
    repeat (4) pulse(1, 6);
    chk("relock", bus.locked, 1);

    // Dead input while locked -> timeout.
    hold_low(40);
    chk("timeout_errcnt", bus.err_cnt, 2);
    pulse(1, 6);
    pulse(1, 6);

    // Wrong duty cycle never locks and never errors.
    model_reset();
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    repeat (8) pulse(2, 5);
    chk("duty_errcnt", bus.err_cnt, 0);

    // Timeout boundary: period 28 is a measurement, 29 times out.
    repeat (5) pulse(1, 6);
    pulse(1, 27);
    pulse(1, 6);
    repeat (5) pulse(1, 6);
    pulse(1, 28);
    pulse(1, 6);

    // Randomized mix biased toward the nominal waveform.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) != 0) pulse(1, 6);
      else begin
        h = $urandom_range(1, 3);
        p = $urandom_range(5, 32);
        pulse(h, p - h);
      end
    end

    // Locked, then asynchronous reset away from any clock edge.
    repeat (5) pulse(1, 6);
    chk("pre_rst_locked", bus.locked, 1);
    #2 sys_rst_n = 1'b0;
    #1 check_zero("async_rst");
    model_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pulse(1, 6);
      chk("rst_relock", bus.locked, (i == 4) ? 1 : 0);
    end

    // Saturation: each 31-cycle pulse times out from acquire.
    for (int i = 0; i < 262; i++) pulse(1, 30);
    hold_low(40);
    chk("err_sat", bus.err_cnt, 255);

    repeat (5) @(negedge sys_clk);
    chk("meas_left", exp_p.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
